// File: rtl/adder_pkg.sv
// Shared constants and types for the registered ripple-carry adder.
package adder_pkg;
  localparam int ADDER_WIDTH = 8;
  typedef logic [ADDER_WIDTH-1:0] operand_t;
endpackage

// File: rtl/full_adder_1_bit.sv
// One-bit full adder stage; purely combinational.
module full_adder_1_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  logic p;

  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);
endmodule

// File: rtl/full_adder_8_bit.sv
// Registered unsigned adder: {cout, s} = a + b + cin, one-cycle latency.
// Ripple chain of one-bit stages feeding WIDTH+1 output flops.
module full_adder_8_bit
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout
);
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    full_adder_1_bit u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .s    (sum[i]),
      .cout (carry[i+1])
    );
  end

  // Outputs come only from these flops; reset clears them regardless of clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s    <= '0;
      cout <= 1'b0;
    end else begin
      s    <= sum;
      cout <= carry[WIDTH];
    end
  end
endmodule

// File: tb/tb_full_adder_8_bit.sv
// Self-checking bench for full_adder_8_bit: directed boundaries plus random sums.
module tb_full_adder_8_bit;
  logic       clk;
  logic       rst;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic [7:0] s;
  logic       cout;

  int n_checks;
  int n_fails;

  full_adder_8_bit #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .s    (s),
    .cout (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int exp_s, input int exp_c);
    n_checks++;
    assert (s === 8'(exp_s)) else begin
      n_fails++;
      $error("FAIL %s: s=%0d expected %0d", tag, s, exp_s);
    end
    n_checks++;
    assert (cout === 1'(exp_c)) else begin
      n_fails++;
      $error("FAIL %s: cout=%0d expected %0d", tag, cout, exp_c);
    end
  endtask

  // Reference: plain integer addition, split into the low 8 bits and carry.
  task automatic apply_and_check(input string tag, input int va, input int vb,
                                 input int vc, input bit check_hold);
    int total;
    @(negedge clk);
    a   = 8'(va);
    b   = 8'(vb);
    cin = 1'(vc);
    total = va + vb + vc;
    @(posedge clk);
    #1;
    check(tag, total % 256, total / 256);
    if (check_hold) begin
      #3;
      check({tag, "_hold"}, total % 256, total / 256);
    end
  endtask

  initial begin
    int ra, rb, rc;
    n_checks = 0;
    n_fails  = 0;

    // Reset held with live inputs: outputs stay zero across clock edges.
    rst = 1'b1;
    a = 8'd200; b = 8'd3; cin = 1'b1;
    #2;
    check("reset_immediate", 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_held", 0, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_release_no_edge", 0, 0);
    @(posedge clk);
    #1;
    check("first_capture", 204, 0);

    apply_and_check("sum_0_0_0",     0,   0, 0, 1'b1);
    apply_and_check("sum_200_3_1", 200,   3, 1, 1'b1);
    apply_and_check("sum_39_30_0",  39,  30, 0, 1'b1);
    apply_and_check("sum_10_32_1",  10,  32, 1, 1'b1);

    apply_and_check("wrap_255_0_1",   255,   0, 1, 1'b1);
    apply_and_check("max_255_255_1",  255, 255, 1, 1'b1);
    apply_and_check("msb_128_128_0",  128, 128, 0, 1'b1);
    apply_and_check("cin_only",         0,   0, 1, 1'b1);

    // Back-to-back vectors on consecutive edges.
    apply_and_check("b2b_1", 1, 1, 0, 1'b0);
    apply_and_check("b2b_2", 2, 2, 0, 1'b0);
    apply_and_check("b2b_3", 3, 3, 1, 1'b0);

    // Mid-operation reset: registered 7 and pending 200 must never appear.
    @(negedge clk);
    a = 8'd100; b = 8'd100; cin = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    check("midrst_async", 0, 0);
    a = 8'd5; b = 8'd6;
    #1;
    rst = 1'b0;
    #1;
    check("midrst_after_release", 0, 0);
    @(posedge clk);
    #1;
    check("midrst_next_capture", 11, 0);

    for (int i = 0; i < 10000; i++) begin
      ra = int'($urandom_range(255, 0));
      rb = int'($urandom_range(255, 0));
      rc = int'($urandom_range(1, 0));
      apply_and_check("random", ra, rb, rc, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/full_adder_8_bit.md
Name: full_adder_8_bit

Overview:
- Registered 8-bit ripple-carry adder: s/cout = a + b + cin, captured on the clock edge.
- Datapath leaf used wherever a pipelined unsigned add with carry-in/out is needed, e.g. ALU stage or accumulator.
- Purely arithmetic; no handshake; one result per clock.

Parameters:
- WIDTH, 8, operand and sum width in bits. Behaviour must be correct for any WIDTH >= 1; 8 is the only required build.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- a  input  WIDTH  unsigned operand A.
- b  input  WIDTH  unsigned operand B.
- cin  input  1  carry-in, added at bit 0.
- s  output  WIDTH  registered sum, low WIDTH bits of a+b+cin.
- cout  output  1  registered carry-out, bit WIDTH of a+b+cin.

Behaviour:
- Interface rule: one clock; reset is asynchronous and active-high.
- Arithmetic:
  - Full result = a + b + cin, computed at WIDTH+1 bits, unsigned.
  - s = result[WIDTH-1:0]; cout = result[WIDTH].
  - No signed overflow flag.
- Combinational core:
  - Ripple chain of WIDTH one-bit full adders.
  - Per stage: sum_i = a_i ^ b_i ^ c_i; c_{i+1} = (a_i & b_i) | (c_i & (a_i ^ b_i)).
  - c_0 = cin; cout = c_WIDTH.
- Timing:
  - s and cout are driven only from flops.
  - Latency exactly 1 cycle: inputs sampled at rising edge N appear on s/cout after edge N and are held until edge N+1.
  - New inputs may be applied every cycle; throughput 1 per clock.
- Reset:
  - While rst = 1: s = 0 and cout = 0 immediately, independent of clk.
  - On rst deassertion: the first capture is at the next rising clk edge after release.
  - If rst asserts mid-operation, any in-flight result is discarded.
- Boundaries:
  - Wrap-around: 255 + 0 + 1 gives s = 0, cout = 1.
  - Maximum: 255 + 255 + 1 gives s = 255, cout = 1.
  - cin alone with a = b = 0 gives s = 1.
  - X/Z on inputs is not filtered.
- No internal state other than the WIDTH+1 output flops.

Decomposition:
- Shared package adder_pkg:
  - constant ADDER_WIDTH = 8 (default for WIDTH).
  - typedef operand_t = logic [ADDER_WIDTH-1:0].
- Sub-module full_adder_1_bit:
  - ports a, b, cin, s, cout; purely combinational.
  - Instantiated WIDTH times via generate loop, carry chained LSB to MSB.
- Top-level full_adder_8_bit: generate chain plus output register with async reset.

Test Plan:
- Reset: assert rst with a = 200, b = 3, cin = 1 -> s = 0, cout = 0 immediately and held; release, next edge -> s = 204, cout = 0.
- Directed sums, one per cycle, each checked one cycle later:
  - 0+0+0 -> 0/0
  - 200+3+1 -> 204/0
  - 39+30+0 -> 69/0
  - 10+32+1 -> 43/0
- Carry boundaries:
  - 255+0+1 -> s = 0, cout = 1
  - 255+255+1 -> s = 255, cout = 1
  - 128+128+0 -> s = 0, cout = 1
  - 0+0+1 -> s = 1, cout = 0
- Latency/throughput: back-to-back vectors 1+1+0, 2+2+0, 3+3+1 on consecutive edges -> outputs 2, 4, 7 on the following consecutive cycles; no bubbles.
- Mid-operation reset: drive 100+100+0, pulse rst between clock edges -> outputs drop to 0/0 asynchronously; the pre-reset result never appears.
- Random: 10k random a/b/cin with one-cycle-delayed reference model {cout,s} = a+b+cin -> zero mismatches.
